gf180mcu_osu_sc_12t_gate_bist: RTL and testbench
================================================

GF180MCU_OSU_SC_12T_GATE_BIST -- requirements
Module: gf180mcu_osu_sc_12T_gate_bist

Interface
REQ-001 SHALL have parameter TRUTH, default 4'b1000, giving the expected Y for pattern index {A,B}; bit n is the expected Y for index n (AND2 = 4'b1000).
REQ-002 SHALL have parameter SETTLE, default 2, range 1..15: drive cycles per pattern before sampling.
REQ-003 SHALL have parameter LOOPS, default 1, range 1..64: number of full 4-pattern sweeps per run.
REQ-004 SHALL have port CLK, input, 1: sole clock; all state updates on rising edge.
REQ-005 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port START, input, 1: run request, sampled only in IDLE.
REQ-007 SHALL have port ABORT, input, 1: synchronous run cancel.
REQ-008 SHALL have port Y, input, 1: DUT gate output under test.
REQ-009 SHALL have port A, output, 1: DUT input A, registered.
REQ-010 SHALL have port B, output, 1: DUT input B, registered.
REQ-011 SHALL have port BUSY, output, 1: run in progress.
REQ-012 SHALL have port DONE, output, 1: one-cycle run-complete pulse.
REQ-013 SHALL have port PASS, output, 1: last completed run had zero mismatches.
REQ-014 SHALL have port ERRCNT, output, 8: mismatch count of current/last run.
REQ-015 SHALL have port FAILVEC, output, 4: bit n set if pattern n mismatched at least once.

Function
REQ-016 SHALL implement FSM states IDLE, SETTLE, SAMPLE, FINISH.
REQ-017 SHALL, in IDLE with START=1 and ABORT=0, go to SETTLE with idx=0, loop=0, settle counter=SETTLE, and clear ERRCNT, FAILVEC and PASS.
REQ-018 SHALL drive A=idx[1] and B=idx[0] in SETTLE and SAMPLE, and A=B=0 in IDLE and FINISH.
REQ-019 SHALL remain in SETTLE for exactly SETTLE cycles per pattern, then enter SAMPLE for exactly 1 cycle.
REQ-020 SHALL, in SAMPLE, compare Y against TRUTH[idx]; on mismatch, increment ERRCNT (saturating at 255) and set FAILVEC[idx].
REQ-021 SHALL ignore Y, including X values, outside SAMPLE.
REQ-022 SHALL, after SAMPLE: if idx<3, increment idx and go to SETTLE; if idx=3 and loop<LOOPS-1, set idx=0, increment loop and go to SETTLE; otherwise go to FINISH.
REQ-023 SHALL hold BUSY=1 in SETTLE and SAMPLE only, for exactly 4*LOOPS*(SETTLE+1) consecutive cycles per run.
REQ-024 SHALL, in FINISH, assert DONE=1 and BUSY=0 for one cycle, load PASS=(ERRCNT==0) including the final SAMPLE's result, then return to IDLE.
REQ-025 SHALL hold ERRCNT, FAILVEC and PASS stable from FINISH until the next accepted START or RST.
REQ-026 SHALL ignore START when not in IDLE; back-to-back runs require one IDLE cycle after FINISH.
REQ-027 SHALL, on ABORT=1 in SETTLE or SAMPLE, go to IDLE next cycle without pulsing DONE; it SHALL force PASS=0, keep partial ERRCNT/FAILVEC, and discard any compare from that cycle.
REQ-028 SHALL give ABORT priority over START in IDLE (no run starts).

Reset
REQ-029 SHALL, on RST=1 at a clock edge, override all other inputs and force state IDLE, A=0, B=0, BUSY=0, DONE=0, PASS=0, ERRCNT=0, FAILVEC=0, idx=0, loop=0.
REQ-030 SHALL, on RST mid-run, abandon the run with no DONE pulse; the first START accepted after RST deasserts begins a fresh run.

Verification
REQ-031 Defaults, Y=A&B model, START at cycle 0 -> {A,B}=00,01,10,11 each for 3 cycles; BUSY for 12 cycles; DONE in cycle 13; PASS=1, ERRCNT=0, FAILVEC=0000.
REQ-032 Defaults, Y stuck at 0 -> ERRCNT=1, FAILVEC=1000, PASS=0.
REQ-033 LOOPS=2, SETTLE=1, Y stuck at 1 -> BUSY for 16 cycles; ERRCNT=6, FAILVEC=0111, PASS=0.
REQ-034 Defaults, ABORT in cycle 5 -> IDLE, A=B=0 and BUSY=0 next cycle; no DONE; PASS=0; START during run also ignored.
REQ-035 RST during SAMPLE of pattern 2 -> all outputs 0 next cycle; a new START then gives a full 12-cycle run with correct results.
REQ-036 LOOPS=64, Y=~(A&B) -> ERRCNT saturates at 255, not 0; FAILVEC=1111; DONE after 768 BUSY cycles.

Source files
------------

// File: rtl/gf180mcu_osu_sc_12t_gate_bist.sv
// Built-in self test for a 2-input standard cell: sweeps the four {A,B}
// patterns LOOPS times and counts output mismatches against TRUTH.
module gf180mcu_osu_sc_12t_gate_bist #(
   parameter logic [3:0]  TRUTH  = 4'b1000,
   parameter int unsigned SETTLE = 2,
   parameter int unsigned LOOPS  = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       ABORT,
   input  logic       Y,
   output logic       A,
   output logic       B,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS,
   output logic [7:0] ERRCNT,
   output logic [3:0] FAILVEC
);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_FINISH} state_e;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);
   localparam logic [5:0] LAST_LOOP   = 6'(LOOPS - 1);

   state_e     state_q;
   logic [1:0] idx_q;
   logic [5:0] loop_q;
   logic [3:0] cnt_q;
   logic       a_q, b_q, busy_q, done_q, pass_q;
   logic [7:0] err_q;
   logic [3:0] fail_q;

   logic       miss;
   logic [1:0] idx_d;
   logic [7:0] err_d;
   logic [3:0] fail_d;

   // Result of comparing the current pattern; only committed in SAMPLE.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      miss   = (Y != TRUTH[idx_q]);
      idx_d  = idx_q + 2'd1;
      err_d  = err_q;
      fail_d = fail_q;
      if (miss) begin
         if (err_q != 8'hFF) err_d = err_q + 8'd1;
         fail_d[idx_q] = 1'b1;
      end
   end

   // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         loop_q  <= 6'd0;
         cnt_q   <= 4'd0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 8'd0;
         fail_q  <= 4'd0;
      end else if (ABORT && (state_q == S_SETTLE || state_q == S_SAMPLE)) begin
         // Cancel keeps the partial counts but drops this cycle's compare.
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         loop_q  <= 6'd0;
         {a_q, b_q} <= 2'b00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (START && !ABORT) begin
                  state_q    <= S_SETTLE;
                  idx_q      <= 2'd0;
                  loop_q     <= 6'd0;
                  cnt_q      <= SETTLE_LOAD;
                  {a_q, b_q} <= 2'b00;
                  busy_q     <= 1'b1;
                  pass_q     <= 1'b0;
                  err_q      <= 8'd0;
                  fail_q     <= 4'd0;
               end
            end
            S_SETTLE: begin
               if (cnt_q == 4'd1) state_q <= S_SAMPLE;
               else               cnt_q   <= cnt_q - 4'd1;
            end
            S_SAMPLE: begin
               err_q  <= err_d;
               fail_q <= fail_d;
               if (idx_q != 2'd3) begin
                  idx_q      <= idx_d;
                  {a_q, b_q} <= idx_d;
                  cnt_q      <= SETTLE_LOAD;
                  state_q    <= S_SETTLE;
               end else if (loop_q != LAST_LOOP) begin
                  idx_q      <= 2'd0;
                  loop_q     <= loop_q + 6'd1;
                  {a_q, b_q} <= 2'b00;
                  cnt_q      <= SETTLE_LOAD;
                  state_q    <= S_SETTLE;
               end else begin
                  state_q    <= S_FINISH;
                  {a_q, b_q} <= 2'b00;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  pass_q     <= (err_d == 8'd0);
               end
            end
            S_FINISH: begin
               state_q <= S_IDLE;
               idx_q   <= 2'd0;
               loop_q  <= 6'd0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign A       = a_q;
   assign B       = b_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign PASS    = pass_q;
   assign ERRCNT  = err_q;
   assign FAILVEC = fail_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_gate_bist.sv
// Directed bench for the gate BIST: three instances cover defaults, a
// short two-loop sweep and the 64-loop saturation case.
module tb_gf180mcu_osu_sc_12t_gate_bist;

   logic clk = 1'b0;
   logic rst, start0, abort0, start1, start2;
   logic y0, y1, y2;
   logic a0, b0, busy0, done0, pass0;
   logic a1, b1, busy1, done1, pass1;
   logic a2, b2, busy2, done2, pass2;
   logic [7:0] err0, err1, err2;
   logic [3:0] fail0, fail1, fail2;
   int mode0;  // 0: Y=A&B, 1: stuck 0, 2: stuck 1
   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign y0 = (mode0 == 0) ? (a0 & b0) : (mode0 == 2);
   assign y1 = 1'b1;
   assign y2 = ~(a2 & b2);

   gf180mcu_osu_sc_12t_gate_bist u0 (
      .CLK(clk), .RST(rst), .START(start0), .ABORT(abort0), .Y(y0),
      .A(a0), .B(b0), .BUSY(busy0), .DONE(done0), .PASS(pass0),
      .ERRCNT(err0), .FAILVEC(fail0));

   gf180mcu_osu_sc_12t_gate_bist #(.TRUTH(4'b1000), .SETTLE(1), .LOOPS(2)) u1 (
      .CLK(clk), .RST(rst), .START(start1), .ABORT(1'b0), .Y(y1),
      .A(a1), .B(b1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
      .ERRCNT(err1), .FAILVEC(fail1));

   gf180mcu_osu_sc_12t_gate_bist #(.TRUTH(4'b1000), .SETTLE(2), .LOOPS(64)) u2 (
      .CLK(clk), .RST(rst), .START(start2), .ABORT(1'b0), .Y(y2),
      .A(a2), .B(b2), .BUSY(busy2), .DONE(done2), .PASS(pass2),
      .ERRCNT(err2), .FAILVEC(fail2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Starts a run on u0 and walks cycles 1..12; returns early after the
   // cycle in which ABORT or RST is driven. A stray START is driven in cycle 3.
   task automatic run0(input int abort_at, input int rst_at);
      start0 = 1'b1;
      tick;
      start0 = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         check("run_seq", {busy0, done0, a0, b0}, {1'b1, 1'b0, 2'((c - 1) / 3)});
         if (c == 1) check("run_clear", {pass0, err0, fail0}, 13'd0);
         if (c == 3) start0 = 1'b1;
         if (c == abort_at) abort0 = 1'b1;
         if (c == rst_at) rst = 1'b1;
         tick;
         start0 = 1'b0;
         abort0 = 1'b0;
         rst    = 1'b0;
         if (c == abort_at || c == rst_at) return;
      end
   endtask

   task automatic end_check0(input logic exp_pass, input logic [7:0] exp_err,
                             input logic [3:0] exp_fail);
      check("fin_flags", {done0, busy0, a0, b0}, 4'b1000);
      check("fin_pass", pass0, exp_pass);
      check("fin_err", err0, exp_err);
      check("fin_fail", fail0, exp_fail);
      tick;
      check("idle_flags", {done0, busy0, a0, b0}, 4'b0000);
      check("hold_res", {pass0, err0, fail0}, {exp_pass, exp_err, exp_fail});
   endtask

   initial begin
      int n;
      int bad;
      rst = 1'b1; start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      mode0 = 0;
      tick;
      tick;
      check("rst_u0", {a0, b0, busy0, done0, pass0, err0, fail0}, 17'd0);
      check("rst_u1", {a1, b1, busy1, done1, pass1, err1, fail1}, 17'd0);
      check("rst_u2", {a2, b2, busy2, done2, pass2, err2, fail2}, 17'd0);
      rst = 1'b0;
      tick;

      // Good AND gate: clean pass, DONE in cycle 13.
      mode0 = 0;
      run0(0, 0);
      end_check0(1'b1, 8'd0, 4'b0000);

      // Y stuck at 0: only pattern 3 fails.
      mode0 = 1;
      run0(0, 0);
      end_check0(1'b0, 8'd1, 4'b1000);

      // Abort in SETTLE of pattern 1; pattern 0 mismatch already counted.
      mode0 = 2;
      run0(5, 0);
      check("abort_out", {busy0, done0, a0, b0, pass0}, 5'd0);
      check("abort_err", err0, 8'd1);
      check("abort_fail", fail0, 4'b0001);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (done0 || busy0) bad++;
         tick;
      end
      check("abort_nodone", bad, 0);

      // Abort in SAMPLE of pattern 1 drops that cycle's mismatch.
      run0(6, 0);
      check("abort_smp_out", {busy0, done0, a0, b0, pass0}, 5'd0);
      check("abort_smp_err", err0, 8'd1);
      check("abort_smp_fail", fail0, 4'b0001);

      // ABORT wins over START in IDLE.
      start0 = 1'b1;
      abort0 = 1'b1;
      tick;
      start0 = 1'b0;
      abort0 = 1'b0;
      check("prio_busy", busy0, 1'b0);
      check("prio_hold", err0, 8'd1);
      tick;

      // RST in SAMPLE of pattern 2, then a fresh clean run.
      run0(0, 9);
      check("midrst", {a0, b0, busy0, done0, pass0, err0, fail0}, 17'd0);
      tick;
      check("midrst_nodone", done0, 1'b0);
      mode0 = 0;
      run0(0, 0);
      end_check0(1'b1, 8'd0, 4'b0000);

      // LOOPS=2, SETTLE=1, Y stuck at 1.
      start1 = 1'b1;
      tick;
      start1 = 1'b0;
      n = 0;
      bad = 0;
      while (busy1 && n < 100) begin
         if ({a1, b1} != 2'((n / 2) % 4)) bad++;
         n++;
         tick;
      end
      check("u1_busy_len", n, 16);
      check("u1_ab_seq", bad, 0);
      check("u1_done", done1, 1'b1);
      check("u1_err", err1, 8'd6);
      check("u1_fail", fail1, 4'b0111);
      check("u1_pass", pass1, 1'b0);

      // LOOPS=64 with an inverted gate: count saturates at 255.
      start2 = 1'b1;
      tick;
      start2 = 1'b0;
      n = 0;
      bad = 0;
      while (busy2 && n < 2000) begin
         if ({a2, b2} != 2'((n / 3) % 4)) bad++;
         n++;
         tick;
      end
      check("u2_busy_len", n, 768);
      check("u2_ab_seq", bad, 0);
      check("u2_done", done2, 1'b1);
      check("u2_err", err2, 8'd255);
      check("u2_fail", fail2, 4'b1111);
      check("u2_pass", pass2, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
